// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Instruction issue stage in front of a two-unit ALU (arithmetic and shift).
// Upstream instructions are buffered in a DEPTH-entry FIFO. One entry is
// popped per cycle while the downstream is not stalled. The popped operands
// and op fields are registered onto the ALU inputs. A one-cycle enable strobe
// is raised for the targeted unit. A result-valid pipeline of ALU_LAT stages
// then reports when that unit's result is ready.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   ALU_LAT  cycles from enable strobe to res_valid (>= 1)
//
// Ports
//   clock         single clock, rising edge
//   reset_n       asynchronous reset, ACTIVE-HIGH despite its name
//   in_valid      upstream offers {in_instr, in_op1, in_op2}
//   in_ready      FIFO has room (combinational from occupancy only)
//   in_instr      [7:6] unit (00 nop, 01 arith, 10 shift, 11 illegal),
//                 [5:3] opselect, [2:0] operation
//   in_op1/in_op2 operands
//   hold          downstream stall, blocks popping
//   aluin1/aluin2 registered operands of the last popped entry
//   opselect      registered [5:3] of the last popped entry
//   operation     registered [2:0] of the last popped entry
//   enable_arith  one-cycle strobe, arithmetic unit
//   enable_shift  one-cycle strobe, shift unit
//   res_valid     a strobe issued ALU_LAT cycles ago has completed
//   res_is_arith  that completed strobe went to the arithmetic unit
//   illegal_cnt   popped illegal instructions, saturating at 255
//   issue_cnt     issued strobes, wrapping at 65536
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_instr,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic        hold,
  output logic [31:0] aluin1,
  output logic [31:0] aluin2,
  output logic [2:0]  opselect,
  output logic [2:0]  operation,
  output logic        enable_arith,
  output logic        enable_shift,
  output logic        res_valid,
  output logic        res_is_arith,
  output logic [7:0]  illegal_cnt,
  output logic [15:0] issue_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    UNIT_NOP     = 2'b00,
    UNIT_ARITH   = 2'b01,
    UNIT_SHIFT   = 2'b10,
    UNIT_ILLEGAL = 2'b11
  } unit_e;

  typedef struct packed {
    logic [7:0]  instr;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  // Issue registers
  logic [31:0]        aluin1_q,    aluin1_d;
  logic [31:0]        aluin2_q,    aluin2_d;
  logic [2:0]         opselect_q,  opselect_d;
  logic [2:0]         operation_q, operation_d;
  logic               en_arith_q,  en_arith_d;
  logic               en_shift_q,  en_shift_d;
  logic [7:0]         illegal_q,   illegal_d;
  logic [15:0]        issue_q,     issue_d;

  // Result-valid pipeline; stage 0 captures the strobe one cycle after issue
  logic [ALU_LAT-1:0] res_v_q, res_v_d;
  logic [ALU_LAT-1:0] res_a_q, res_a_d;

  logic   push;
  logic   pop;
  entry_t head;
  unit_e  head_unit;

  assign in_ready  = (count_q < FULL_COUNT);
  // A full FIFO refuses a push even when it pops in the same cycle, so
  // in_ready never depends on hold.
  assign push      = in_valid && in_ready;
  assign pop       = (count_q != '0) && !hold;
  assign head      = mem_q[rd_ptr_q];
  assign head_unit = unit_e'(head.instr[7:6]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    aluin1_d    = aluin1_q;
    aluin2_d    = aluin2_q;
    opselect_d  = opselect_q;
    operation_d = operation_q;
    en_arith_d  = 1'b0;
    en_shift_d  = 1'b0;
    illegal_d   = illegal_q;
    issue_d     = issue_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      // Fields are latched for every unit code, including nop and illegal.
      aluin1_d    = head.op1;
      aluin2_d    = head.op2;
      opselect_d  = head.instr[5:3];
      operation_d = head.instr[2:0];
      unique case (head_unit)
        UNIT_ARITH:   en_arith_d = 1'b1;
        UNIT_SHIFT:   en_shift_d = 1'b1;
        UNIT_ILLEGAL: if (illegal_q != 8'hFF) illegal_d = illegal_q + 8'd1;
        default:      ;
      endcase
    end

    if (en_arith_d || en_shift_d) issue_d = issue_q + 16'd1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Strobes already issued advance regardless of hold.
    res_v_d[0] = en_arith_q || en_shift_q;
    res_a_d[0] = en_arith_q;
    for (int i = 1; i < ALU_LAT; i++) begin
      res_v_d[i] = res_v_q[i-1];
      res_a_d[i] = res_a_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      aluin1_q    <= '0;
      aluin2_q    <= '0;
      opselect_q  <= '0;
      operation_q <= '0;
      en_arith_q  <= 1'b0;
      en_shift_q  <= 1'b0;
      illegal_q   <= '0;
      issue_q     <= '0;
      res_v_q     <= '0;
      res_a_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      aluin1_q    <= aluin1_d;
      aluin2_q    <= aluin2_d;
      opselect_q  <= opselect_d;
      operation_q <= operation_d;
      en_arith_q  <= en_arith_d;
      en_shift_q  <= en_shift_d;
      illegal_q   <= illegal_d;
      issue_q     <= issue_d;
      res_v_q     <= res_v_d;
      res_a_q     <= res_a_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset. Clearing count and
  // pointers already makes every stale entry unreachable. Writes that slip
  // in while reset is held are likewise never read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: in_instr, op1: in_op1, op2: in_op2};
  end

  assign aluin1       = aluin1_q;
  assign aluin2       = aluin2_q;
  assign opselect     = opselect_q;
  assign operation    = operation_q;
  assign enable_arith = en_arith_q;
  assign enable_shift = en_shift_q;
  assign res_valid    = res_v_q[ALU_LAT-1];
  assign res_is_arith = res_a_q[ALU_LAT-1];
  assign illegal_cnt  = illegal_q;
  assign issue_cnt    = issue_q;

endmodule
